// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - handshaked RV32-style ALU with registered output and iterative RV32M multiply/divide
module alu_seq_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        mop_q, mop_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;

    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   base_res;
    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              is_div, div_zero, div_ovf;
    logic [XLEN:0]     add_ext;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_sub;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   m_res;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    assign shamt = input2[SH_W-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'd0:    base_res = input1 & input2;
            4'd1:    base_res = input1 | input2;
            4'd2:    base_res = input1 + input2;
            4'd3:    base_res = input1 - input2;
            4'd4:    base_res = {{(XLEN-1){1'b0}}, ($signed(input1) < $signed(input2))};
            4'd5:    base_res = input1 ^ input2;
            4'd6:    base_res = input1 << shamt;
            4'd7:    base_res = input1 >> shamt;
            4'd8:    base_res = XLEN'($signed(input1) >>> shamt);
            4'd9:    base_res = {{(XLEN-1){1'b0}}, (input1 < input2)};
            4'd10:   base_res = ~(input1 | input2);
            default: base_res = '0;
        endcase
    end

    always_comb begin
        a_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        b_signed = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        sign_a   = a_signed & input1[XLEN-1];
        sign_b   = b_signed & input2[XLEN-1];
        mag_a    = sign_a ? (~input1 + 1'b1) : input1;
        mag_b    = sign_b ? (~input2 + 1'b1) : input2;
        is_div   = op[2];
        div_zero = is_div && (input2 == '0);
        div_ovf  = is_div && !op[0] && (input1 == MIN_NEG) && (input2 == '1);
    end

    always_comb begin
        add_ext   = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q})
                             : {1'b0, acc_q[2*XLEN-1:XLEN]};
        rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, opb_q};
        if (!mop_q[2]) begin
            step_acc = {add_ext, acc_q[XLEN-1:1]};
        end else if (!rem_sub[XLEN]) begin
            step_acc = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q ? (~step_acc + 1'b1) : step_acc;
        div_val  = mop_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
        if (!mop_q[2]) begin
            m_res = (mop_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            m_res = neg_q ? (~div_val + 1'b1) : div_val;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mop_d    = mop_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!op[4]) begin
                        result_d = base_res;
                        state_d  = S_DONE;
                    end else if (div_zero) begin
                        result_d = op[1] ? input1 : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op[1] ? '0 : input1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(XLEN);
                        mop_d   = op[2:0];
                        neg_d   = (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
                        opb_d   = is_div ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = m_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mop_q    <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mop_q    <= mop_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule
